// File: rtl/mem_stage.sv
// MEM pipeline stage: register writeback, data-memory store handshake and sticky halt.
// Define MEM_TIMEOUT_EN to enable the store-ack watchdog and mem_err reporting.
module mem_stage #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 6,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              halted,
    input  logic              data_rw,
    input  logic [DATA_W-1:0] alu_output,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic              mem_ack,
    output logic              freeze,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              halted_out,
    output logic              mem_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t state;

    // Stall and request are decoded from state alone so reset clears them immediately.
    assign freeze  = (state == WAIT) || (state == HALT);
    assign mem_req = (state == WAIT);

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    logic [CNT_W-1:0] watchdog;
`else
    assign mem_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            halted_out <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            mem_err    <= 1'b0;
            watchdog   <= '0;
`endif
        end else begin
            rf_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (halted) begin
                            state      <= HALT;
                            halted_out <= 1'b1;
                        end else if (!data_rw) begin
                            rf_we    <= 1'b1;
                            rf_waddr <= write_addr;
                            rf_wdata <= alu_output;
                        end else begin
                            mem_addr  <= write_addr;
                            mem_wdata <= alu_output;
                            state     <= WAIT;
`ifdef MEM_TIMEOUT_EN
                            watchdog  <= '0;
`endif
                        end
                    end
                end
                WAIT: begin
                    if (mem_ack) begin
                        state <= IDLE;
`ifdef MEM_TIMEOUT_EN
                    // Ack on the expiry edge takes priority over the timeout.
                    end else if (watchdog == CNT_W'(TIMEOUT - 1)) begin
                        state   <= IDLE;
                        mem_err <= 1'b1;
                    end else begin
                        watchdog <= watchdog + 1'b1;
`endif
                    end
                end
                HALT:    state <= HALT;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a transaction-level reference model.
module tb_mem_stage;

    localparam int DATA_W  = 8;
    localparam int ADDR_W  = 6;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              halted = 1'b0;
    logic              data_rw = 1'b0;
    logic [DATA_W-1:0] alu_output = '0;
    logic [ADDR_W-1:0] write_addr = '0;
    logic              mem_ack = 1'b0;
    logic              freeze, mem_req, rf_we, halted_out, mem_err;
    logic [ADDR_W-1:0] mem_addr, rf_waddr;
    logic [DATA_W-1:0] mem_wdata, rf_wdata;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    mem_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .halted(halted),
        .data_rw(data_rw), .alu_output(alu_output), .write_addr(write_addr),
        .mem_ack(mem_ack), .freeze(freeze), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .halted_out(halted_out), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: "busy" = store outstanding, "stopped" = halt seen since reset.
    bit                busy, stopped, m_err, m_we;
    int                waited;
    logic [ADDR_W-1:0] m_addr, m_waddr;
    logic [DATA_W-1:0] m_wdata, m_data;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 0; stopped <= 0; m_err <= 0; m_we <= 0; waited <= 0;
            m_addr <= '0; m_data <= '0; m_waddr <= '0; m_wdata <= '0;
        end else begin
            m_we <= 0;
            if (busy) begin
                waited <= waited + 1;
                if (mem_ack) busy <= 0;
`ifdef MEM_TIMEOUT_EN
                else if (waited + 1 == TIMEOUT) begin busy <= 0; m_err <= 1; end
`endif
            end else if (!stopped && in_valid) begin
                if (halted) stopped <= 1;
                else if (!data_rw) begin
                    m_we <= 1; m_waddr <= write_addr; m_wdata <= alu_output;
                end else begin
                    busy <= 1; waited <= 0; m_addr <= write_addr; m_data <= alu_output;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("freeze", 32'(freeze), 32'(busy || stopped));
            check("mem_req", 32'(mem_req), 32'(busy));
            check("mem_addr", 32'(mem_addr), 32'(m_addr));
            check("mem_wdata", 32'(mem_wdata), 32'(m_data));
            check("rf_we", 32'(rf_we), 32'(m_we));
            check("rf_waddr", 32'(rf_waddr), 32'(m_waddr));
            check("rf_wdata", 32'(rf_wdata), 32'(m_wdata));
            check("halted_out", 32'(halted_out), 32'(stopped));
            check("mem_err", 32'(mem_err), 32'(m_err));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; halted = 0; data_rw = 0; mem_ack = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_freeze"}, 32'(freeze), 0);
        check({tag, "_mem_req"}, 32'(mem_req), 0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 0);
        check({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
        check({tag, "_rf_we"}, 32'(rf_we), 0);
        check({tag, "_rf_waddr"}, 32'(rf_waddr), 0);
        check({tag, "_rf_wdata"}, 32'(rf_wdata), 0);
        check({tag, "_halted_out"}, 32'(halted_out), 0);
        check({tag, "_mem_err"}, 32'(mem_err), 0);
    endtask

    initial begin
        int n;
        chk_en = 1;
        tick(); tick();
        check_all_zero("reset");
        rst_n = 1;
        tick();

        // Single writeback
        in_valid = 1; data_rw = 0; write_addr = 6'h05; alu_output = 8'hA3;
        tick();
        in_valid = 0;
        check("wb_we", 32'(rf_we), 1);
        check("wb_waddr", 32'(rf_waddr), 32'h05);
        check("wb_wdata", 32'(rf_wdata), 32'hA3);
        tick();
        check("wb_we_drop", 32'(rf_we), 0);

        // Store acked after three WAIT cycles
        in_valid = 1; data_rw = 1; write_addr = 6'h3F; alu_output = 8'h7E;
        tick();
        idle_inputs();
        for (int c = 1; c <= 3; c++) begin
            check("st_req", 32'(mem_req), 1);
            check("st_freeze", 32'(freeze), 1);
            check("st_addr", 32'(mem_addr), 32'h3F);
            check("st_wdata", 32'(mem_wdata), 32'h7E);
            if (c == 3) mem_ack = 1;
            tick();
        end
        mem_ack = 0;
        check("st_req_drop", 32'(mem_req), 0);
        check("st_freeze_drop", 32'(freeze), 0);

        // Writeback held during WAIT, performed once IDLE returns
        in_valid = 1; data_rw = 1; write_addr = 6'h10; alu_output = 8'h55;
        tick();
        data_rw = 0; write_addr = 6'h07; alu_output = 8'h11;
        tick();
        check("held_ignored", 32'(rf_we), 0);
        alu_output = 8'h22; mem_ack = 1;
        tick();
        mem_ack = 0;
        check("held_idle_we", 32'(rf_we), 0);
        check("held_idle_req", 32'(mem_req), 0);
        tick();
        in_valid = 0;
        check("held_we", 32'(rf_we), 1);
        check("held_wdata", 32'(rf_wdata), 32'h22);
        check("held_waddr", 32'(rf_waddr), 32'h07);

        // Halt is sticky and blocks later writebacks
        in_valid = 1; halted = 1;
        tick();
        halted = 0; data_rw = 0; alu_output = 8'h33;
        for (int c = 0; c < 6; c++) begin
            check("halt_out", 32'(halted_out), 1);
            check("halt_freeze", 32'(freeze), 1);
            check("halt_no_we", 32'(rf_we), 0);
            check("halt_no_req", 32'(mem_req), 0);
            mem_ack = 1;
            tick();
        end
        idle_inputs();

        // Asynchronous reset during WAIT
        rst_n = 0; tick(); rst_n = 1; tick();
        in_valid = 1; data_rw = 1; write_addr = 6'h2A; alu_output = 8'hC4;
        tick();
        idle_inputs();
        check("rw_req", 32'(mem_req), 1);
        rst_n = 0;
        #1;
        check("rw_req_async", 32'(mem_req), 0);
        check("rw_freeze_async", 32'(freeze), 0);
        tick();
        rst_n = 1;
        tick();
        check_all_zero("post_reset");

        // Store with no acknowledge
        in_valid = 1; data_rw = 1; write_addr = 6'h01; alu_output = 8'h99;
        tick();
        idle_inputs();
        n = 0;
        while (mem_req && n < 40) begin
            n++;
            tick();
        end
`ifdef MEM_TIMEOUT_EN
        check("to_cycles", 32'(n), 32'(TIMEOUT));
        check("to_err", 32'(mem_err), 1);
`else
        check("noto_cycles", 32'(n), 40);
        check("noto_err", 32'(mem_err), 0);
`endif
        rst_n = 0; tick(); rst_n = 1; tick();

        // Randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            if (!rst_n) rst_n = 1;
            else if ($urandom_range(0, 119) == 0) rst_n = 0;
            in_valid   = ($urandom_range(0, 2) != 0);
            halted     = ($urandom_range(0, 149) == 0);
            data_rw    = $urandom_range(0, 1) == 1;
            alu_output = DATA_W'($urandom);
            write_addr = ADDR_W'($urandom);
            mem_ack    = ($urandom_range(0, 4) == 0);
            tick();
        end
        idle_inputs();
        tick();
        chk_en = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
